mul_upper_pipe: RTL and testbench

MUL_UPPER_PIPE -- requirements
Module: mul_upper_pipe

---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_limb_pp.sv | 21 ++
 rtl/mul_upper_pipe.sv | 121 ++++++++++++
 tb/tb_mul_upper_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants and index helpers for the limb-decomposed upper-half multiplier.
package mul_pkg;

  localparam int MUL_SIZE_DEF = 80;
  localparam int NUM_LIMBS    = 4;
  localparam int PROD_W       = 2 * MUL_SIZE_DEF;

  function automatic int num_limbs(input int size, input int limb);
    return size / limb;
  endfunction

  function automatic int prod_width(input int size);
    return 2 * size;
  endfunction

  // LSB position of limb idx inside an operand.
  function automatic int limb_lsb(input int idx, input int limb);
    return idx * limb;
  endfunction

endpackage

// File: rtl/mul_limb_pp.sv
// One registered LIMB x LIMB unsigned partial product; holds its value while en is low.
module mul_limb_pp #(
  parameter int LIMB = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [LIMB-1:0]     x,
  input  logic [LIMB-1:0]     y,
  output logic [2*LIMB-1:0]   p
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p <= '0;
    end else if (en) begin
      p <= (2*LIMB)'(x) * (2*LIMB)'(y);
    end
  end

endmodule

// File: rtl/mul_upper_pipe.sv
// Three-stage pipelined multiplier returning product bits [SHIFT+MUL_SIZE-1:SHIFT].
// Define MUL_UPPER_ROUND_EN to round half-up into the window instead of truncating.
module mul_upper_pipe
  import mul_pkg::*;
#(
  parameter int MUL_SIZE = PROD_W / 2,
  parameter int LIMB     = MUL_SIZE_DEF / NUM_LIMBS,
  parameter int SHIFT    = 80,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_SIZE-1:0] a,
  input  logic [MUL_SIZE-1:0] b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MUL_SIZE-1:0] res,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int N  = num_limbs(MUL_SIZE, LIMB);
  localparam int PW = prod_width(MUL_SIZE);

  if ((MUL_SIZE % LIMB) != 0 || SHIFT < 0 || SHIFT > MUL_SIZE || TAG_W < 1) begin : g_bad_params
    $error("mul_upper_pipe: invalid MUL_SIZE/LIMB/SHIFT/TAG_W combination");
  end

`ifdef MUL_UPPER_ROUND_EN
  localparam logic [PW-1:0] ROUND_K =
    (SHIFT > 0) ? (PW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : {PW{1'b0}};
`else
  localparam logic [PW-1:0] ROUND_K = {PW{1'b0}};
`endif

  logic                stall;
  logic                advance;
  logic                v1, v2, v3;
  logic [TAG_W-1:0]    t1, t2, t3;
  logic [2*LIMB-1:0]   pp      [N][N];
  logic [PW-1:0]       row_sum [N];
  logic [PW-1:0]       row_q   [N];
  logic [PW-1:0]       full_sum;
  logic [PW-1:0]       full_q;
  logic                unused_full;

  // A single global hold: the pipeline only freezes when a finished result is refused.
  assign stall     = v3 && !out_ready;
  assign advance   = !stall;
  assign in_ready  = rst_n && !stall;
  assign out_valid = v3;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      mul_limb_pp #(.LIMB(LIMB)) u_pp (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (advance && in_valid),
        .x     (a[limb_lsb(gi, LIMB) +: LIMB]),
        .y     (b[limb_lsb(gj, LIMB) +: LIMB]),
        .p     (pp[gi][gj])
      );
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_sum[i] = '0;
      for (int j = 0; j < N; j++) begin
        row_sum[i] = row_sum[i] + (PW'(pp[i][j]) << (LIMB * (i + j)));
      end
    end
  end

  always_comb begin
    full_sum = ROUND_K;
    for (int i = 0; i < N; i++) begin
      full_sum = full_sum + row_q[i];
    end
  end

  // Data registers load only behind a valid bit so res/out_tag keep the last delivered value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      t1     <= '0;
      t2     <= '0;
      t3     <= '0;
      full_q <= '0;
      for (int i = 0; i < N; i++) begin
        row_q[i] <= '0;
      end
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        t1 <= in_tag;
      end
      if (v1) begin
        t2 <= t1;
        for (int i = 0; i < N; i++) begin
          row_q[i] <= row_sum[i];
        end
      end
      if (v2) begin
        t3     <= t2;
        full_q <= full_sum;
      end
    end
  end

  assign res         = full_q[SHIFT +: MUL_SIZE];
  assign out_tag     = t3;
  assign unused_full = ^full_q;

endmodule

// File: tb/tb_mul_upper_pipe.sv
// Self-checking bench for mul_upper_pipe: directed corner cases plus a randomized scoreboard run.
module tb_mul_upper_pipe;

  localparam int MS = 80;
  localparam int LB = 20;
  localparam int SH = 80;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MS-1:0] a = '0;
  logic [MS-1:0] b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MS-1:0] res;
  logic [TW-1:0] out_tag;

  int total = 0;
  int bad = 0;

  logic [MS-1:0] exp_res_q [$];
  logic [TW-1:0] exp_tag_q [$];
  bit            acc;
  bit            dlv;
  logic [MS-1:0] d_res;
  logic [TW-1:0] d_tag;

  localparam logic [MS-1:0] ALL_ONES = {MS{1'b1}};
  localparam logic [MS-1:0] TOP_BIT  = {1'b1, {(MS-1){1'b0}}};

  always #5 clk = ~clk;

  mul_upper_pipe #(
    .MUL_SIZE (MS),
    .LIMB     (LB),
    .SHIFT    (SH),
    .TAG_W    (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .out_tag   (out_tag)
  );

  // Reference: exact double-width product, optional half-up bias, then the window.
  function automatic logic [MS-1:0] ref_window(input logic [MS-1:0] x, input logic [MS-1:0] y);
    logic [2*MS-1:0] full;
    full = {{MS{1'b0}}, x} * {{MS{1'b0}}, y};
`ifdef MUL_UPPER_ROUND_EN
    full = full + ((2*MS)'(1) << (SH - 1));
`endif
    return full[SH +: MS];
  endfunction

  // Samples handshakes just before the next edge, records accepted ops, then steps one cycle.
  task automatic tick();
    #1;
    acc   = in_valid && in_ready;
    dlv   = out_valid && out_ready;
    d_res = res;
    d_tag = out_tag;
    if (acc) begin
      exp_res_q.push_back(ref_window(a, b));
      exp_tag_q.push_back(in_tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = ALL_ONES;
    b        = ALL_ONES;
    in_tag   = 4'd9;
    tick();
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (res !== '0) begin bad++; $display("[TB] FAIL reset_res: got %h want 0", res); end
    total++; if (out_tag !== '0) begin bad++; $display("[TB] FAIL reset_out_tag: got %h want 0", out_tag); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    exp_res_q.delete();
    exp_tag_q.delete();
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_max_operand();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = ALL_ONES;
    b         = ALL_ONES;
    in_tag    = 4'd5;
    tick();
    in_valid = 1'b0;
    total++; if (acc !== 1'b1) begin bad++; $display("[TB] FAIL max_accept: got %b want 1", acc); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL max_lat1: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL max_lat2: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL max_lat3: got %b want 1", out_valid); end
    total++; if (res !== 80'hFFFF_FFFF_FFFF_FFFF_FFFE) begin bad++; $display("[TB] FAIL max_res: got %h want fffffffffffffffffffe", res); end
    total++; if (out_tag !== 4'd5) begin bad++; $display("[TB] FAIL max_tag: got %h want 5", out_tag); end
    tick();
    exp_res_q.delete();
    exp_tag_q.delete();
  endtask

  task automatic test_round_edges();
    logic [MS-1:0] want_half;
`ifdef MUL_UPPER_ROUND_EN
    want_half = 80'd1;
`else
    want_half = 80'd0;
`endif
    in_valid = 1'b1;
    a = TOP_BIT; b = 80'd2; in_tag = 4'd1;
    tick();
    a = TOP_BIT; b = 80'd1; in_tag = 4'd2;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || res !== 80'd1) begin bad++; $display("[TB] FAIL edge_2pow80: got v=%b res=%h want v=1 res=1", out_valid, res); end
    tick();
    total++; if (out_valid !== 1'b1 || res !== want_half) begin bad++; $display("[TB] FAIL edge_2pow79: got v=%b res=%h want v=1 res=%h", out_valid, res, want_half); end
    tick();
    exp_res_q.delete();
    exp_tag_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [MS-1:0] want_r;
    logic [TW-1:0] want_t;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a        = {$urandom(), $urandom(), $urandom()};
      b        = {$urandom(), $urandom(), $urandom()};
      in_tag   = TW'(k + 1);
      tick();
      total++; if (acc !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b want 1", k, acc); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      want_r = exp_res_q.pop_front();
      want_t = exp_tag_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || res !== want_r || out_tag !== want_t) begin
        bad++;
        $display("[TB] FAIL b2b_result[%0d]: got v=%b res=%h tag=%h want v=1 res=%h tag=%h",
                 k, out_valid, res, out_tag, want_r, want_t);
      end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [MS-1:0] r0;
    logic [TW-1:0] t0;
    logic [MS-1:0] want_r;
    logic [TW-1:0] want_t;
    int n;
    exp_res_q.delete();
    exp_tag_q.delete();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a        = {$urandom(), $urandom(), $urandom()};
      b        = {$urandom(), $urandom(), $urandom()};
      in_tag   = TW'(7 + k);
      tick();
    end
    in_valid  = 1'b1;
    in_tag    = 4'hF;
    out_ready = 1'b0;
    total++; if (res !== exp_res_q[0]) begin bad++; $display("[TB] FAIL stall_head: got %h want %h", res, exp_res_q[0]); end
    r0 = res;
    t0 = out_tag;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (acc !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1 || res !== r0 || out_tag !== t0) begin
        bad++;
        $display("[TB] FAIL stall_hold[%0d]: got acc=%b rdy=%b v=%b res=%h tag=%h want acc=0 rdy=0 v=1 res=%h tag=%h",
                 k, acc, in_ready, out_valid, res, out_tag, r0, t0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (dlv) begin
        n++;
        total++;
        if (exp_res_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL stall_extra: got res=%h tag=%h want none", d_res, d_tag);
        end else begin
          want_r = exp_res_q.pop_front();
          want_t = exp_tag_q.pop_front();
          if (d_res !== want_r || d_tag !== want_t) begin
            bad++;
            $display("[TB] FAIL stall_order: got res=%h tag=%h want res=%h tag=%h", d_res, d_tag, want_r, want_t);
          end
        end
      end
    end
    total++; if (n != 3) begin bad++; $display("[TB] FAIL stall_count: got %0d want 3", n); end
  endtask

  task automatic test_reset_mid();
    int seen;
    exp_res_q.delete();
    exp_tag_q.delete();
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      a        = {$urandom(), $urandom(), $urandom()} | 80'd1;
      b        = {$urandom(), $urandom(), $urandom()} | TOP_BIT;
      in_tag   = TW'(3 + k);
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0 || res !== '0) begin bad++; $display("[TB] FAIL midreset_clear: got v=%b res=%h want v=0 res=0", out_valid, res); end
    exp_res_q.delete();
    exp_tag_q.delete();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL midreset_ghost: got %0d results want 0", seen); end
  endtask

  task automatic test_random();
    int sent;
    int rcvd;
    int cycles;
    int sel;
    bit have_last;
    logic [MS-1:0] last;
    logic [MS-1:0] want_r;
    logic [TW-1:0] want_t;
    exp_res_q.delete();
    exp_tag_q.delete();
    sent = 0; rcvd = 0; cycles = 0; have_last = 1'b0; last = '0;
    while ((sent < 1000 || rcvd < 1000) && cycles < 20000) begin
      in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? ALL_ONES : (sel == 1) ? TOP_BIT : {$urandom(), $urandom(), $urandom()};
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? ALL_ONES : (sel == 1) ? 80'd1 : {$urandom(), $urandom(), $urandom()};
      in_tag    = TW'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cycles++;
      if (acc) sent++;
      if (dlv) begin
        rcvd++;
        total++;
        if (exp_res_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL rand_extra: got res=%h want none", d_res);
        end else begin
          want_r = exp_res_q.pop_front();
          want_t = exp_tag_q.pop_front();
          if (d_res !== want_r || d_tag !== want_t) begin
            bad++;
            $display("[TB] FAIL rand_result[%0d]: got res=%h tag=%h want res=%h tag=%h", rcvd, d_res, d_tag, want_r, want_t);
          end
        end
        last      = d_res;
        have_last = 1'b1;
      end
      if (!out_valid && have_last) begin
        total++;
        if (res !== last) begin bad++; $display("[TB] FAIL rand_idle_hold: got %h want %h", res, last); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (sent != 1000 || rcvd != 1000 || exp_res_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL rand_complete: got sent=%0d rcvd=%0d pending=%0d want 1000/1000/0", sent, rcvd, exp_res_q.size());
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_max_operand();
    test_round_edges();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
